// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg
//   Shared definitions for the ALU issue stage: default datapath width, the
//   ALU func codes produced by decode, the MIPS opcodes that are recognised,
//   and the packet type carried through the issue register.
//   No ports (package).
package alu_issue_stage_pkg;

    localparam int          XLEN_DEF         = 32;
    localparam logic [5:0]  ILLEGAL_FUNC_DEF = 6'h3F;

    // ALU func codes used by I-type and branch decode (R-type passes funct).
    localparam logic [5:0]  FN_ADD  = 6'h20;
    localparam logic [5:0]  FN_ADDU = 6'h21;
    localparam logic [5:0]  FN_AND  = 6'h24;
    localparam logic [5:0]  FN_OR   = 6'h25;
    localparam logic [5:0]  FN_XOR  = 6'h26;
    localparam logic [5:0]  FN_SLT  = 6'h2A;
    localparam logic [5:0]  FN_BEQ  = 6'h38;
    localparam logic [5:0]  FN_BNE  = 6'h39;
    localparam logic [5:0]  FN_BLEZ = 6'h3A;
    localparam logic [5:0]  FN_BGTZ = 6'h3B;
    localparam logic [5:0]  FN_BGEZ = 6'h3C;
    localparam logic [5:0]  FN_LUI  = 6'h3D;

    // MIPS primary opcodes.
    localparam logic [5:0]  OP_SPECIAL = 6'h00;
    localparam logic [5:0]  OP_REGIMM  = 6'h01;
    localparam logic [5:0]  OP_BEQ     = 6'h04;
    localparam logic [5:0]  OP_BNE     = 6'h05;
    localparam logic [5:0]  OP_BLEZ    = 6'h06;
    localparam logic [5:0]  OP_BGTZ    = 6'h07;
    localparam logic [5:0]  OP_ADDI    = 6'h08;
    localparam logic [5:0]  OP_ADDIU   = 6'h09;
    localparam logic [5:0]  OP_SLTI    = 6'h0A;
    localparam logic [5:0]  OP_ANDI    = 6'h0C;
    localparam logic [5:0]  OP_ORI     = 6'h0D;
    localparam logic [5:0]  OP_XORI    = 6'h0E;
    localparam logic [5:0]  OP_LUI     = 6'h0F;
    localparam logic [5:0]  OP_LW      = 6'h23;
    localparam logic [5:0]  OP_SW      = 6'h2B;

    // REGIMM rt field selecting BGEZ.
    localparam logic [4:0]  RT_BGEZ    = 5'b00001;

    typedef struct packed {
        logic [5:0]  func;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] inst;
        logic        is_branch;
        logic [31:0] br_target;
        logic        illegal;
    } issue_pkt_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
//   Bundles the upstream (decoded-register packet) and downstream (ALU op)
//   valid/ready channels of the issue stage.
//   master : drives in_* and out_ready (upstream source + execute sink)
//   slave  : the issue stage itself, drives in_ready and out_*
interface alu_issue_stage_if;
    import alu_issue_stage_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [XLEN_DEF-1:0] in_inst;
    logic [XLEN_DEF-1:0] in_pc;
    logic [XLEN_DEF-1:0] in_rs_val;
    logic [XLEN_DEF-1:0] in_rt_val;
    logic                out_valid;
    logic                out_ready;
    logic [5:0]          out_func;
    logic [XLEN_DEF-1:0] out_in1;
    logic [XLEN_DEF-1:0] out_in2;
    logic [XLEN_DEF-1:0] out_inst;
    logic                out_is_branch;
    logic [XLEN_DEF-1:0] out_br_target;
    logic                out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, in_rs_val, in_rt_val, out_ready,
        input  in_ready, out_valid, out_func, out_in1, out_in2, out_inst,
               out_is_branch, out_br_target, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, in_rs_val, in_rt_val, out_ready,
        output in_ready, out_valid, out_func, out_in1, out_in2, out_inst,
               out_is_branch, out_br_target, out_illegal
    );

endinterface

// File: rtl/alu_issue_stage_skid.sv
// pipe_skid_buf
//   Generic 2-entry valid/ready register. The main entry feeds the outputs
//   directly; the skid entry catches the one packet that can arrive in the
//   cycle in which the main entry stalls. in_ready is a flop (inverse of the
//   next skid occupancy), so there is no combinational ready path upstream.
//   Ports: clk, rst_b (sync, active-high), in_valid/in_ready/in_data,
//          out_valid/out_ready/out_data.
module pipe_skid_buf
    import alu_issue_stage_pkg::*;
#(
    parameter type T = issue_pkt_t
) (
    input  logic clk,
    input  logic rst_b,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    T     main_r;
    T     skid_r;
    logic main_valid_r;
    logic skid_valid_r;
    logic in_ready_r;

    T     main_nxt_s;
    T     skid_nxt_s;
    logic main_valid_nxt_s;
    logic skid_valid_nxt_s;
    logic in_fire_s;
    logic out_fire_s;

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = main_valid_r & out_ready;

    // Next-state for both entries; skid only fills while main is held.
    always_comb begin
        main_nxt_s       = main_r;
        skid_nxt_s       = skid_r;
        main_valid_nxt_s = main_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (!main_valid_r || out_fire_s) begin
            // Main slot frees up: older skid entry has priority over new input.
            if (skid_valid_r) begin
                main_nxt_s       = skid_r;
                main_valid_nxt_s = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else if (in_fire_s) begin
                main_nxt_s       = in_data;
                main_valid_nxt_s = 1'b1;
            end else begin
                main_valid_nxt_s = 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                skid_nxt_s       = in_data;
                skid_valid_nxt_s = 1'b1;
            end else begin
                skid_valid_nxt_s = skid_valid_r;
            end
        end
    end

    // Entry and ready registers; reset empties both entries and zeroes data.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            main_r       <= '0;
            skid_r       <= '0;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            main_r       <= main_nxt_s;
            skid_r       <= skid_nxt_s;
            main_valid_r <= main_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            in_ready_r   <= ~skid_valid_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_r;

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Decode/issue stage in front of the ALU. Maps MIPS opcode/funct onto the
//   ALU func code, selects and extends operands, computes the branch target
//   and issues one registered op per cycle through a 2-entry skid register.
//   Ports: clk, rst_b (sync, active-high), bus (alu_issue_stage_if.slave):
//          in_valid/in_ready/in_inst/in_pc/in_rs_val/in_rt_val upstream,
//          out_valid/out_ready/out_func/out_in1/out_in2/out_inst/
//          out_is_branch/out_br_target/out_illegal downstream.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int         XLEN         = XLEN_DEF,
    parameter logic [5:0] ILLEGAL_FUNC = ILLEGAL_FUNC_DEF
) (
    input  logic               clk,
    input  logic               rst_b,
    alu_issue_stage_if.slave   bus
);

    issue_pkt_t dec_pkt_s;
    issue_pkt_t out_pkt_s;

    // Anything not recognised leaves illegal=1 with zero operands.
    function automatic issue_pkt_t decode_f(
        input logic [XLEN-1:0] inst,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] rs_val,
        input logic [XLEN-1:0] rt_val
    );
        issue_pkt_t      p;
        logic [XLEN-1:0] sext;
        logic [XLEN-1:0] zext;
        sext        = {{(XLEN-16){inst[15]}}, inst[15:0]};
        zext        = {{(XLEN-16){1'b0}}, inst[15:0]};
        p.func      = ILLEGAL_FUNC;
        p.in1       = {XLEN{1'b0}};
        p.in2       = {XLEN{1'b0}};
        p.inst      = inst;
        p.is_branch = 1'b0;
        p.br_target = pc + 32'd4 + (sext << 2);
        p.illegal   = 1'b1;
        case (inst[31:26])
            OP_SPECIAL: begin
                case (inst[5:0])
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h18, 6'h1A, 6'h20,
                    6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: begin
                        p.func = inst[5:0]; p.in1 = rs_val; p.in2 = rt_val; p.illegal = 1'b0;
                    end
                    default: p.illegal = 1'b1;
                endcase
            end
            OP_ADDI:      begin p.func = FN_ADD;  p.in1 = rs_val; p.in2 = sext; p.illegal = 1'b0; end
            OP_ADDIU:     begin p.func = FN_ADDU; p.in1 = rs_val; p.in2 = sext; p.illegal = 1'b0; end
            OP_SLTI:      begin p.func = FN_SLT;  p.in1 = rs_val; p.in2 = sext; p.illegal = 1'b0; end
            OP_ANDI:      begin p.func = FN_AND;  p.in1 = rs_val; p.in2 = zext; p.illegal = 1'b0; end
            OP_ORI:       begin p.func = FN_OR;   p.in1 = rs_val; p.in2 = zext; p.illegal = 1'b0; end
            OP_XORI:      begin p.func = FN_XOR;  p.in1 = rs_val; p.in2 = zext; p.illegal = 1'b0; end
            OP_LUI:       begin p.func = FN_LUI;  p.in1 = rs_val; p.in2 = zext; p.illegal = 1'b0; end
            OP_LW, OP_SW: begin p.func = FN_ADD;  p.in1 = rs_val; p.in2 = sext; p.illegal = 1'b0; end
            OP_BEQ: begin
                p.func = FN_BEQ;  p.in1 = rs_val; p.in2 = rt_val; p.is_branch = 1'b1; p.illegal = 1'b0;
            end
            OP_BNE: begin
                p.func = FN_BNE;  p.in1 = rs_val; p.in2 = rt_val; p.is_branch = 1'b1; p.illegal = 1'b0;
            end
            OP_BLEZ: begin
                p.func = FN_BLEZ; p.in1 = rs_val; p.is_branch = 1'b1; p.illegal = 1'b0;
            end
            OP_BGTZ: begin
                p.func = FN_BGTZ; p.in1 = rs_val; p.is_branch = 1'b1; p.illegal = 1'b0;
            end
            OP_REGIMM: begin
                if (inst[20:16] == RT_BGEZ) begin
                    p.func = FN_BGEZ; p.in1 = rs_val; p.is_branch = 1'b1; p.illegal = 1'b0;
                end else begin
                    p.illegal = 1'b1;
                end
            end
            default: p.illegal = 1'b1;
        endcase
        return p;
    endfunction

    // Decode the incoming packet; registered by the skid buffer below.
    always_comb begin
        dec_pkt_s = decode_f(bus.in_inst, bus.in_pc, bus.in_rs_val, bus.in_rt_val);
    end

    pipe_skid_buf #(
        .T (issue_pkt_t)
    ) u_skid (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (dec_pkt_s),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_pkt_s)
    );

    assign bus.out_func      = out_pkt_s.func;
    assign bus.out_in1       = out_pkt_s.in1;
    assign bus.out_in2       = out_pkt_s.in2;
    assign bus.out_inst      = out_pkt_s.inst;
    assign bus.out_is_branch = out_pkt_s.is_branch;
    assign bus.out_br_target = out_pkt_s.br_target;
    assign bus.out_illegal   = out_pkt_s.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [5:0]  func;
        logic [31:0] in1;
        logic [31:0] in2;
        logic        br;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    localparam int NVEC = 20;

    logic clk;
    logic rst_b;
    int   num_checks;
    int   num_pass;
    vec_t vecs [NVEC];

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end else begin
            num_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt);
        bus.in_valid  = 1'b1;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.in_rs_val = rs;
        bus.in_rt_val = rt;
    endtask

    initial begin
        num_checks = 0;
        num_pass   = 0;
        //        inst          pc            rs            rt            func   in1           in2           br    tgt           ill
        vecs[0]  = '{32'h2409FFFF, 32'h00000100, 32'h00000005, 32'h0, 6'h21, 32'h00000005, 32'hFFFFFFFF, 1'b0, 32'h00000100, 1'b0};
        vecs[1]  = '{32'h3409FFFF, 32'h00000200, 32'h00000007, 32'h0, 6'h25, 32'h00000007, 32'h0000FFFF, 1'b0, 32'h00000200, 1'b0};
        vecs[2]  = '{32'h1000FFFF, 32'h00400000, 32'h00000011, 32'h22, 6'h38, 32'h00000011, 32'h00000022, 1'b1, 32'h00400000, 1'b0};
        vecs[3]  = '{32'h10000000, 32'hFFFFFFFC, 32'h00000003, 32'h3, 6'h38, 32'h00000003, 32'h00000003, 1'b1, 32'h00000000, 1'b0};
        vecs[4]  = '{32'h012A4020, 32'h00000000, 32'h00000010, 32'h20, 6'h20, 32'h00000010, 32'h00000020, 1'b0, 32'h00010084, 1'b0};
        vecs[5]  = '{32'h00094080, 32'h00000000, 32'h00000001, 32'h55, 6'h00, 32'h00000001, 32'h00000055, 1'b0, 32'h00010204, 1'b0};
        vecs[6]  = '{32'h00000001, 32'h00000000, 32'h00000009, 32'h9, 6'h3F, 32'h00000000, 32'h00000000, 1'b0, 32'h00000008, 1'b1};
        vecs[7]  = '{32'h3C011234, 32'h00000000, 32'h00000099, 32'h0, 6'h3D, 32'h00000099, 32'h00001234, 1'b0, 32'h000048D4, 1'b0};
        vecs[8]  = '{32'h28228000, 32'h00000000, 32'h00000005, 32'h0, 6'h2A, 32'h00000005, 32'hFFFF8000, 1'b0, 32'hFFFE0004, 1'b0};
        vecs[9]  = '{32'h30228000, 32'h00000000, 32'h00000005, 32'h0, 6'h24, 32'h00000005, 32'h00008000, 1'b0, 32'hFFFE0004, 1'b0};
        vecs[10] = '{32'hAC220010, 32'h00000000, 32'h00001000, 32'h0, 6'h20, 32'h00001000, 32'h00000010, 1'b0, 32'h00000044, 1'b0};
        vecs[11] = '{32'h18200003, 32'h00001000, 32'h00000007, 32'h8, 6'h3A, 32'h00000007, 32'h00000000, 1'b1, 32'h00001010, 1'b0};
        vecs[12] = '{32'h04210002, 32'h00002000, 32'h00000004, 32'h6, 6'h3C, 32'h00000004, 32'h00000000, 1'b1, 32'h0000200C, 1'b0};
        vecs[13] = '{32'h04220002, 32'h00002000, 32'h00000004, 32'h6, 6'h3F, 32'h00000000, 32'h00000000, 1'b0, 32'h0000200C, 1'b1};
        vecs[14] = '{32'hFC000000, 32'h00000000, 32'h00000004, 32'h6, 6'h3F, 32'h00000000, 32'h00000000, 1'b0, 32'h00000004, 1'b1};
        vecs[15] = '{32'h14220001, 32'h00000010, 32'h00000001, 32'h2, 6'h39, 32'h00000001, 32'h00000002, 1'b1, 32'h00000018, 1'b0};
        vecs[16] = '{32'h1C200000, 32'h00000000, 32'h0000000A, 32'hB, 6'h3B, 32'h0000000A, 32'h00000000, 1'b1, 32'h00000004, 1'b0};
        vecs[17] = '{32'h3822FFFF, 32'h00000000, 32'h0000000C, 32'h0, 6'h26, 32'h0000000C, 32'h0000FFFF, 1'b0, 32'h00000000, 1'b0};
        vecs[18] = '{32'h2022FFFE, 32'h00000000, 32'h0000000D, 32'h0, 6'h20, 32'h0000000D, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFC, 1'b0};
        vecs[19] = '{32'h8C22FFFC, 32'h00000000, 32'h0000000E, 32'h0, 6'h20, 32'h0000000E, 32'hFFFFFFFC, 1'b0, 32'hFFFFFFF4, 1'b0};

        // Reset held two cycles with in_valid asserted.
        rst_b         = 1'b1;
        bus.out_ready = 1'b1;
        drive(32'h24090001, 32'h0, 32'h7, 32'h0);
        tick();
        tick();
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_out_func",  {26'd0, bus.out_func},  32'd0);
        check("rst_out_in1",   bus.out_in1,            32'd0);
        rst_b = 1'b0;
        tick();
        check("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        check("post_rst_func",  {26'd0, bus.out_func},  32'h21);
        check("post_rst_in1",   bus.out_in1,            32'h7);
        check("post_rst_in2",   bus.out_in2,            32'h1);
        bus.in_valid = 1'b0;

        // Table of decode vectors, one per cycle.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].inst, vecs[i].pc, vecs[i].rs, vecs[i].rt);
            tick();
            bus.in_valid = 1'b0;
            check($sformatf("v%0d_valid", i),  {31'd0, bus.out_valid},     32'd1);
            check($sformatf("v%0d_func", i),   {26'd0, bus.out_func},      {26'd0, vecs[i].func});
            check($sformatf("v%0d_in1", i),    bus.out_in1,                vecs[i].in1);
            check($sformatf("v%0d_in2", i),    bus.out_in2,                vecs[i].in2);
            check($sformatf("v%0d_inst", i),   bus.out_inst,               vecs[i].inst);
            check($sformatf("v%0d_br", i),     {31'd0, bus.out_is_branch}, {31'd0, vecs[i].br});
            check($sformatf("v%0d_tgt", i),    bus.out_br_target,          vecs[i].tgt);
            check($sformatf("v%0d_ill", i),    {31'd0, bus.out_illegal},   {31'd0, vecs[i].ill});
        end
        tick();
        check("drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: three packets against a 3-cycle stall.
        bus.out_ready = 1'b0;
        drive(32'h24090001, 32'h0, 32'h0, 32'h0);
        tick();
        check("bp1_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp1_ready", {31'd0, bus.in_ready},  32'd1);
        check("bp1_inst",  bus.out_inst,           32'h24090001);
        drive(32'h24090002, 32'h0, 32'h0, 32'h0);
        tick();
        check("bp2_ready", {31'd0, bus.in_ready}, 32'd0);
        check("bp2_inst",  bus.out_inst,          32'h24090001);
        check("bp2_in2",   bus.out_in2,           32'h1);
        drive(32'h24090003, 32'h0, 32'h0, 32'h0);
        tick();
        check("bp3_ready", {31'd0, bus.in_ready},  32'd0);
        check("bp3_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp3_inst",  bus.out_inst,           32'h24090001);
        check("bp3_in2",   bus.out_in2,            32'h1);
        bus.out_ready = 1'b1;
        tick();
        check("bp4_inst",  bus.out_inst,          32'h24090002);
        check("bp4_in2",   bus.out_in2,           32'h2);
        check("bp4_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp5_inst",  bus.out_inst,           32'h24090003);
        check("bp5_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();
        check("bp6_valid", {31'd0, bus.out_valid}, 32'd0);

        // Sync reset with both entries occupied.
        bus.out_ready = 1'b0;
        drive(32'h24090004, 32'h0, 32'h0, 32'h0);
        tick();
        drive(32'h24090005, 32'h0, 32'h0, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        check("full_ready", {31'd0, bus.in_ready}, 32'd0);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        check("srst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("srst_ready", {31'd0, bus.in_ready},  32'd1);
        check("srst_inst",  bus.out_inst,           32'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("srst_stale%0d", k), {31'd0, bus.out_valid}, 32'd0);
        end
        drive(32'h24090006, 32'h0, 32'h0, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        check("srst_next_valid", {31'd0, bus.out_valid}, 32'd1);
        check("srst_next_inst",  bus.out_inst,           32'h24090006);

        $display("%0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule
